// File: rtl/maxpool_pkg.sv
// rtl/maxpool_pkg.sv - shared types, constants and helpers for the 2x2 max-pool stream
package maxpool_pkg;

   // Row parity tracker: even rows fill the line buffer, odd rows emit pooled pixels
   typedef enum logic {
      EVEN_ROW = 1'b0,
      ODD_ROW  = 1'b1
   } pool_state_t;

   localparam int          FP_SIGN_BIT = 31;
   localparam logic [31:0] FP_ZERO     = 32'h0000_0000;

   // Bits needed to count 0..n-1 (never less than one bit)
   function automatic int cnt_w(input int n);
      int w;
      w = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << w) < n) w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/maxpool2x2_relu_stream_fp32_max2.sv
// rtl/maxpool2x2_relu_stream_fp32_max2.sv - combinational IEEE-754 single max, first operand wins ties
module fp32_max2
   import maxpool_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   logic        w_sa;
   logic        w_sb;
   logic [30:0] w_ma;
   logic [30:0] w_mb;

   assign w_sa = a[FP_SIGN_BIT];
   assign w_sb = b[FP_SIGN_BIT];
   assign w_ma = a[30:0];
   assign w_mb = b[30:0];

   // Sign-magnitude ordering; +0 and -0 count as equal so a is kept
   always_comb begin
      y = a;
      if ((w_ma == 31'd0) && (w_mb == 31'd0)) begin
         y = a;
      end else if (w_sa != w_sb) begin
         y = w_sa ? b : a;
      end else if (!w_sa) begin
         y = (w_mb > w_ma) ? b : a;
      end else begin
         y = (w_mb < w_ma) ? b : a;
      end
   end

endmodule

// File: rtl/maxpool2x2_relu_stream.sv
// rtl/maxpool2x2_relu_stream.sv - streaming 2x2/stride-2 max-pool, optional ReLU via MAXPOOL_RELU_EN
module maxpool2x2_relu_stream
   import maxpool_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int WIDTH      = 112,
   parameter int HEIGHT     = 112
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_done
);

   localparam int CW = cnt_w(WIDTH);
   localparam int RW = cnt_w(HEIGHT);
   localparam int IW = cnt_w(WIDTH / 2);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

   logic [CW-1:0]         r_col;
   logic [RW-1:0]         r_row;
   pool_state_t           r_state;
   pool_state_t           w_state_next;
   logic [31:0]           r_pair;
   logic [31:0]           r_line_buf [0:WIDTH/2-1];
   logic                  r_valid_out;
   logic                  r_frame_done;
   logic [31:0]           r_data_out;

   logic [31:0]           w_word;
   logic [31:0]           w_hmax;
   logic [31:0]           w_pool;
   logic [IW-1:0]         w_idx;
   logic                  w_col_last;
   logic                  w_row_last;

`ifdef MAXPOOL_RELU_EN
   // Negative inputs (including -0.0) are clamped to +0.0
   assign w_word = data_in[FP_SIGN_BIT] ? FP_ZERO : data_in;
`else
   assign w_word = data_in;
`endif

   assign w_idx      = r_col[IW:1];
   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);

   // Horizontal max of the column pair, then vertical max against the buffered even row
   fp32_max2 u_hmax (.a(r_pair),          .b(w_word), .y(w_hmax));
   fp32_max2 u_vmax (.a(r_line_buf[w_idx]), .b(w_hmax), .y(w_pool));

   // Row parity flips at the last column of every accepted row
   always_comb begin
      w_state_next = r_state;
      if (valid_in && w_col_last) begin
         w_state_next = (r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= EVEN_ROW;
      else      r_state <= w_state_next;
   end

   // Pixel position counters, advanced only by accepted words
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (valid_in) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Pair capture on even columns and pooled output on odd columns of odd rows
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pair       <= FP_ZERO;
         r_data_out   <= FP_ZERO;
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
         if (valid_in) begin
            if (!r_col[0]) begin
               r_pair <= w_word;
            end else if (r_state == ODD_ROW) begin
               r_data_out   <= w_pool;
               r_valid_out  <= 1'b1;
               r_frame_done <= w_row_last && w_col_last;
            end
         end
      end
   end

   // Even-row horizontal maxima; contents are only read after being written this frame
   always_ff @(posedge clk) begin
      if (valid_in && r_col[0] && (r_state == EVEN_ROW)) begin
         r_line_buf[w_idx] <= w_hmax;
      end
   end

   assign valid_out  = r_valid_out;
   assign frame_done = r_frame_done;
   assign data_out   = r_data_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_maxpool2x2_relu_stream.sv
// tb/tb_maxpool2x2_relu_stream.sv - scoreboard bench for the 4x4 max-pool stream
module tb_maxpool2x2_relu_stream;

   localparam int W = 4;
   localparam int H = 4;
   localparam int NPIX = W * H;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [31:0] data_in;
   logic        valid_out;
   logic [31:0] data_out;
   logic        frame_done;

   int          n_checks;
   int          n_fail;
   int          n_out;
   int          n_fd;
   logic        exp_pulse;
   logic [31:0] img [0:NPIX-1];
   logic [32:0] sb [$];
   logic [31:0] out_log [$];
   logic [31:0] ref_log [$];

   maxpool2x2_relu_stream #(
      .DATA_WIDTH(32),
      .WIDTH(W),
      .HEIGHT(H)
   ) dut (
      .clk(clk),
      .rst(rst),
      .valid_in(valid_in),
      .data_in(data_in),
      .valid_out(valid_out),
      .data_out(data_out),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] relu_m(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
      return x[31] ? 32'h0 : x;
`else
      return x;
`endif
   endfunction

   // Signed ordering key: -0 and +0 map to the same key
   function automatic longint fkey(input logic [31:0] x);
      longint m;
      m = longint'(x[30:0]);
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
      return (fkey(b) > fkey(a)) ? b : a;
   endfunction

   function automatic logic [31:0] win_exp(input int r, input int c);
      logic [31:0] top;
      logic [31:0] bot;
      top = fmax(relu_m(img[r*W + c]),     relu_m(img[r*W + c + 1]));
      bot = fmax(relu_m(img[(r+1)*W + c]), relu_m(img[(r+1)*W + c + 1]));
      return fmax(top, bot);
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] v;
      v[31]    = 1'($urandom_range(0, 1));
      v[30:23] = 8'(100 + $urandom_range(0, 50));
      v[22:0]  = 23'($urandom);
      return v;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < NPIX; i++) img[i] = rand_fp();
      img[NPIX-1] = img[NPIX-2];
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in  = 1'b0;
         data_in   = $urandom;
         exp_pulse = 1'b0;
      end
   endtask

   task automatic drive_pix(input int idx);
      int r;
      int c;
      r = idx / W;
      c = idx % W;
      @(negedge clk);
      valid_in  = 1'b1;
      data_in   = img[idx];
      exp_pulse = ((r % 2) == 1) && ((c % 2) == 1);
      if (exp_pulse) begin
         sb.push_back({(r == H-1) && (c == W-1), win_exp(r - 1, c - 1)});
      end
   endtask

   task automatic drive_frame(input int gapmax, input int npix);
      for (int i = 0; i < npix; i++) begin
         if (gapmax > 0) idle($urandom_range(0, gapmax));
         drive_pix(i);
      end
   endtask

   task automatic clear_stats();
      n_out = 0;
      n_fd  = 0;
      out_log.delete();
   endtask

   task automatic finish_run(input string tag, input int outs, input int fds);
      idle(4);
      check_val({tag, "_outs"}, 32'(n_out), 32'(outs));
      check_val({tag, "_fd"}, 32'(n_fd), 32'(fds));
      check_val({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
   endtask

   // Output monitor: sampled 2 time units after the active edge
   always @(posedge clk) begin
      logic [32:0] e;
      #2;
      if (valid_out || exp_pulse) check_val("pulse", {31'b0, valid_out}, {31'b0, exp_pulse});
      if (valid_out) begin
         n_out++;
         if (frame_done) n_fd++;
         out_log.push_back(data_out);
         if (sb.size() == 0) begin
            check_val("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check_val("data", data_out, e[31:0]);
            check_val("frame_done", {31'b0, frame_done}, {31'b0, e[32]});
         end
      end else if (frame_done) begin
         check_val("fd_idle", {31'b0, frame_done}, 32'd0);
      end
   end

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b0;
      valid_in  = 1'b0;
      data_in   = '0;
      exp_pulse = 1'b0;
      clear_stats();
      repeat (3) @(negedge clk);
      check_val("rst_valid", {31'b0, valid_out}, 32'd0);
      check_val("rst_fd", {31'b0, frame_done}, 32'd0);
      check_val("rst_data", data_out, 32'd0);
      rst = 1'b1;
      idle(2);

      // Scenario A: back-to-back, known top-left window
      fill_random();
      img[0] = 32'h3F80_0000; img[1] = 32'h4000_0000;
      img[4] = 32'hC040_0000; img[5] = 32'h3F00_0000;
      clear_stats();
      drive_frame(0, NPIX);
      finish_run("a", 4, 1);
      check_val("a_first", (out_log.size() > 0) ? out_log[0] : 32'hDEAD_BEEF, 32'h4000_0000);
      ref_log = out_log;

      // Same frame with random gaps: identical output sequence
      clear_stats();
      drive_frame(5, NPIX);
      finish_run("gap", 4, 1);
      for (int i = 0; i < 4; i++) begin
         check_val("gap_seq", (i < out_log.size()) ? out_log[i] : 32'hDEAD_BEEF, ref_log[i]);
      end

      // All-negative window
      fill_random();
      img[0] = 32'hBF80_0000; img[1] = 32'hC000_0000;
      img[4] = 32'hC040_0000; img[5] = 32'hC080_0000;
      clear_stats();
      drive_frame(0, NPIX);
      finish_run("neg", 4, 1);
`ifdef MAXPOOL_RELU_EN
      check_val("neg_first", (out_log.size() > 0) ? out_log[0] : 32'hDEAD_BEEF, 32'h0000_0000);
`else
      check_val("neg_first", (out_log.size() > 0) ? out_log[0] : 32'hDEAD_BEEF, 32'hBF80_0000);
`endif

      // Signed zeros: first-operand tie rule
      fill_random();
      img[0] = 32'h0000_0000; img[1] = 32'h8000_0000;
      img[4] = 32'h8000_0000; img[5] = 32'h8000_0000;
      clear_stats();
      drive_frame(1, NPIX);
      finish_run("zero", 4, 1);
      check_val("zero_first", (out_log.size() > 0) ? out_log[0] : 32'hDEAD_BEEF, 32'h0000_0000);

      // Reset after 6 pixels, then a fresh frame
      fill_random();
      clear_stats();
      drive_frame(0, 6);
      @(negedge clk);
      valid_in  = 1'b0;
      exp_pulse = 1'b0;
      rst       = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_val("mid_rst_valid", {31'b0, valid_out}, 32'd0);
      end
      rst = 1'b1;
      check_val("mid_rst_sb", 32'(sb.size()), 32'd0);
      fill_random();
      clear_stats();
      drive_frame(0, NPIX);
      finish_run("fresh", 4, 1);

      // Two frames back-to-back with different contents
      clear_stats();
      for (int i = 0; i < NPIX; i++) img[i] = {1'b0, 8'd140, 23'($urandom)};
      drive_frame(0, NPIX);
      for (int i = 0; i < NPIX; i++) img[i] = {1'b0, 8'd110, 23'($urandom)};
      drive_frame(0, NPIX);
      finish_run("two", 8, 2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/maxpool2x2_relu_stream.md
# maxpool2x2_relu_stream

Streaming 2x2/stride-2 max-pool with optional ReLU that sits directly downstream of a `featuremap_*` conv stage. It consumes that stage's `data_out`/`valid_out` pixel stream (IEEE-754 single, row-major, one feature map) and emits one pooled pixel per 2x2 window. Its output is written into the per-channel FIFO that feeds the next conv layer.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width; the block supports only 32 (IEEE-754 single).
- `WIDTH`, 112, input feature-map columns; must be even.
- `HEIGHT`, 112, input feature-map rows; must be even.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `valid_in`  in  1  input word valid; driven by the conv stage's `valid_out`. There is no backpressure.
- `data_in`  in  DATA_WIDTH  conv-stage output pixel.
- `valid_out`  out  1  single-cycle pulse per pooled pixel.
- `data_out`  out  DATA_WIDTH  pooled pixel.
- `frame_done`  out  1  single-cycle pulse, coincident with the last pooled pixel of a frame.

## Operation
- Counters `col` (0..WIDTH-1) and `row` (0..HEIGHT-1) advance only on cycles where `valid_in`=1.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 at the end of the frame.
- FSM has two states:
  - `EVEN_ROW` (reset state): enter `ODD_ROW` when `col`=WIDTH-1 with `valid_in`.
  - `ODD_ROW`: enter `EVEN_ROW` when `col`=WIDTH-1 with `valid_in`.
- Pre-processing: each accepted word is first passed through ReLU (see Configuration).
- Even column: the word is held in `pair_reg`.
- Odd column: `hmax = max(pair_reg, word)`.
  - In `EVEN_ROW`: `hmax` is written to `line_buf[col>>1]`. `line_buf` has WIDTH/2 entries.
  - In `ODD_ROW`: `data_out <= max(line_buf[col>>1], hmax)` and `valid_out` pulses.
- Max rule, implemented by sub-module `fp32_max2`:
  - Both operands positive: the larger magnitude wins.
  - Signs differ: the positive operand wins.
  - Both negative: the smaller magnitude wins.
  - Equal values, including +0 vs -0: the first operand wins.
  - NaN is not handled; its bits are compared like any other value.
- `frame_done` asserts with `valid_out` when the accepted word is at `row`=HEIGHT-1, `col`=WIDTH-1.
- Output count per frame is (WIDTH/2)*(HEIGHT/2).
- Reset values: `valid_out`=0, `frame_done`=0, `data_out`=0, `col`=0, `row`=0, FSM=`EVEN_ROW`, `pair_reg`=0. `line_buf` is not reset; its contents are don't-care until written.
- Reset mid-frame: the partial frame is discarded. The next `valid_in` is treated as pixel (0,0).

## Timing
- Latency: `valid_out` is registered and asserts exactly 1 cycle after the accepting cycle of pixel (2r+1, 2c+1).
- Gapped `valid_in`: idle cycles hold all state. Output is identical to the back-to-back case, only shifted in time.
- Back-to-back input yields at most one output every 2 cycles, and outputs only during odd rows.
- `line_buf` is read and written in the same cycle only at the same index in different row parities. A write never collides with the read it feeds.
- `data_out` holds its last value between pulses.

## Configuration
- `MAXPOOL_RELU_EN` defined: each input is replaced by `32'h0000_0000` when bit 31 is 1. This includes -0.0, which becomes +0.0. The output is therefore always non-negative.
- `MAXPOOL_RELU_EN` undefined: inputs pass through unmodified and negative values propagate via the signed max rule.
- `fp32_max2` is used in both builds.

## Structure
- Package `maxpool_pkg` contains:
  - the FSM state typedef (`EVEN_ROW`, `ODD_ROW`);
  - localparams `FP_SIGN_BIT`=31 and `FP_ZERO`=32'h0;
  - a counter-width function (clog2).
- Sub-module `fp32_max2` is purely combinational: ports `a`, `b`, `y`, with the tie rule "first operand wins".
- The top module holds the counters, the FSM, `pair_reg`, `line_buf`, and the output registers.

## Test plan
- WIDTH=4, HEIGHT=4, back-to-back input, window {1.0=3F800000, 2.0=40000000, -3.0=C0400000, 0.5=3F000000} in the top-left window -> first `valid_out` carries 40000000. Exactly 4 pulses are produced, and `frame_done` coincides with the 4th.
- Window {-1.0=BF800000, -2.0, -3.0, -4.0}:
  - with `MAXPOOL_RELU_EN` -> 00000000;
  - without it -> BF800000.
- Same frame as the first scenario with random 0–5-cycle gaps on `valid_in` -> the output sequence matches the back-to-back run bit-for-bit.
- Window {+0=00000000, -0=80000000, -0, -0} without ReLU -> output 00000000 (first-operand tie rule).
- `rst` pulled low after 6 pixels of a 4x4 frame, then a full fresh frame is applied -> exactly 4 outputs, all correct for the fresh frame. `valid_out` is 0 during reset.
- Two consecutive 4x4 frames with no gap -> 8 outputs, `frame_done` on the 4th and 8th. Second-frame values do not use stale `line_buf` data.
